// File: rtl/mux_scan_checker.sv
// Scan sequencer for a 16:1 single-bit mux: drives data and select,
// samples the mux output per enabled channel and flags mismatches.
module mux_scan_checker #(
  parameter int NCH  = 16,
  parameter int SELW = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [NCH-1:0]             data_in,
  input  logic [NCH-1:0]             chan_mask,
  output logic [NCH-1:0]             mux_in,
  output logic [SELW-1:0]            mux_sel,
  input  logic                       mux_out,
  output logic                       busy,
  output logic                       done,
  output logic [NCH-1:0]             result,
  output logic [$clog2(NCH+1)-1:0]   err_count,
  output logic                       mismatch
);

  localparam int CW = $clog2(NCH+1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  state_e          state_q;
  logic [NCH-1:0]  mux_in_q;
  logic [NCH-1:0]  mask_q;
  logic [SELW-1:0] sel_q;
  logic [NCH-1:0]  result_q;
  logic [CW-1:0]   err_q;
  logic            mismatch_q;
  logic            done_q;
  logic            busy_q;
  logic            ready_q;

  logic            first_vld_d;
  logic [SELW-1:0] first_sel_d;
  logic            nxt_vld_d;
  logic [SELW-1:0] nxt_sel_d;
  logic            bit_err_d;

  // Descending walk so the lowest qualifying index wins.
  always_comb begin
    first_vld_d = 1'b0;
    first_sel_d = '0;
    nxt_vld_d   = 1'b0;
    nxt_sel_d   = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (chan_mask[i]) begin
        first_vld_d = 1'b1;
        first_sel_d = SELW'(i);
      end
      if (mask_q[i] && (i > int'(sel_q))) begin
        nxt_vld_d = 1'b1;
        nxt_sel_d = SELW'(i);
      end
    end
  end

  assign bit_err_d = mux_out != mux_in_q[sel_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mux_in_q   <= '0;
      mask_q     <= '0;
      sel_q      <= '0;
      result_q   <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            mux_in_q   <= data_in;
            mask_q     <= chan_mask;
            result_q   <= '0;
            err_q      <= '0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            if (first_vld_d) begin
              sel_q   <= first_sel_d;
              state_q <= DRIVE;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DRIVE: begin
          state_q <= SAMPLE;
        end
        SAMPLE: begin
          result_q[sel_q] <= mux_out;
          if (bit_err_d) begin
            err_q      <= err_q + 1'b1;
            mismatch_q <= 1'b1;
          end
          if (nxt_vld_d) begin
            sel_q   <= nxt_sel_d;
            state_q <= DRIVE;
          end else begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign start_ready = ready_q;
  assign mux_in      = mux_in_q;
  assign mux_sel     = sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign err_count   = err_q;
  assign mismatch    = mismatch_q;

endmodule

// File: doc/mux_scan_checker.md
Name: mux_scan_checker

Overview:
- Sequencer that sits directly upstream of the 16:1 single-bit channel mux.
- Drives the mux data bus and 4-bit select, walks the select through every enabled channel, and samples the mux output back.
- Reassembles the sampled bits into a word, compares them against the driven word, and reports a per-scan result, a mismatch count and a done pulse.
- Used for mux bring-up and as a serial channel reader in built-in self-test.

Parameters:
- NCH, 16, number of mux channels (fixed by the mux; not to be overridden).
- SELW, 4, select width, log2(NCH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  request to begin a scan.
- start_ready  output  1  block can accept a request (IDLE only).
- data_in  input  16  word to drive onto the mux; latched at accept.
- chan_mask  input  16  bit i=1 means channel i is scanned; latched at accept.
- mux_in  output  16  registered copy of the latched data_in, drives the mux data bus.
- mux_sel  output  4  registered select, drives the mux select.
- mux_out  input  1  mux output returned to this block.
- busy  output  1  high in DRIVE, SAMPLE and DONE.
- done  output  1  one-cycle pulse at scan completion.
- result  output  16  sampled bits; bit i = mux_out captured while mux_sel==i; masked bits are 0.
- err_count  output  5  number of enabled channels where the sampled bit != mux_in[i], range 0..16.
- mismatch  output  1  err_count != 0; valid from the done cycle onward.

Behaviour:
- Reset, asynchronous: state=IDLE, mux_in=0, mux_sel=0, result=0, err_count=0, mismatch=0, done=0, busy=0, start_ready=1.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid & start_ready at an edge: latch data_in into mux_in and chan_mask into an internal mask; clear result and err_count.
  - If mask==0, go to DONE.
  - Otherwise go to DRIVE with mux_sel = lowest set mask index.
- DRIVE: one settle cycle; mux_sel stable. Go to SAMPLE.
- SAMPLE:
  - At the edge leaving SAMPLE: result[mux_sel] <= mux_out.
  - If mux_out != mux_in[mux_sel], err_count increments.
  - Next mux_sel = lowest set mask index strictly greater than the current one. If one exists, go to DRIVE; otherwise go to DONE.
  - Indices never wrap: channel 15 is always last.
- DONE:
  - done=1 for exactly one cycle; mismatch is valid.
  - Go to IDLE.
- Holding after a scan:
  - result, err_count and mismatch hold until the next accept.
  - mux_in and mux_sel hold their last values in IDLE.
- Latency: done asserts 2·N+1 cycles after the accept edge, where N = popcount(mask). For N=0, done asserts in the cycle after accept.
- start_valid is ignored outside IDLE. data_in and chan_mask changes after accept have no effect.
- start_valid held high: the next scan is accepted in the first IDLE cycle after DONE, so there is exactly one idle cycle between scans.
- Reset asserted mid-scan: immediate return to reset values. A partial result is discarded and done does not pulse.
- err_count width is sufficient for 16, so no saturation is needed.

Test Plan:
- Reset, then data_in=0xA5C3 and chan_mask=0xFFFF with an ideal mux model → mux_sel steps 0..15, each value held 2 cycles; done pulses 33 cycles after accept; result=0xA5C3, err_count=0, mismatch=0.
- data_in=0xFFFF, chan_mask=0xFFFF, bench forces mux_out=0 when mux_sel==5 → result=0xFFDF, err_count=1, mismatch=1.
- chan_mask=0x8001, data_in=0x8001 → mux_sel visits only 0 then 15; done pulses 5 cycles after accept; result=0x8001.
- chan_mask=0x0000 → done pulses the cycle after accept; result=0, err_count=0; busy high for one cycle only.
- start_valid held high for two scans with data 0x1234 then 0x00FF, full mask → second accept occurs in the IDLE cycle following done; results are 0x1234 then 0x00FF.
- rst asserted while mux_sel==7 mid-scan → all outputs return to 0 and start_ready=1 asynchronously; no done pulse; the next scan completes normally.
